// File: rtl/clock_phase_gen_pkg.sv
`default_nettype none
// ============================================================================
// clk_phase_pkg : CPU-phase state type and divider helper functions
// Rev 1.0 : initial release
// ============================================================================
package clk_phase_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } cpu_state_t;

  // log2 for the supported mem multipliers (1, 2, 4, 8)
  function automatic int mult_shift(input int mult);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      if ((1 << i) == mult) s = i;
    end
    return s;
  endfunction

  // A half period must split evenly into mem phases, each at least 2 cycles
  function automatic logic legal_half(input int value, input int mult);
    return ((value % mult) == 0) && (value >= 2 * mult);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_phase_gen_if.sv
`default_nettype none
// ============================================================================
// clock_phase_gen_if : reload port, CPU control and phase outputs
// Rev 1.0 : initial release
// ============================================================================
interface clock_phase_gen_if #(
  parameter int CNT_W = 8
);
  logic             load_valid;
  logic [CNT_W-1:0] load_data;
  logic             load_ready;
  logic             load_err;
  logic             halt;
  logic             step;
  logic             halted;
  logic             cpu_phi;
  logic             mem_phi;
  logic             vid_phi;
  logic             cpu_rise;
  logic             cpu_fall;

  modport master (
    output load_valid, load_data, halt, step,
    input  load_ready, load_err, halted, cpu_phi, mem_phi, vid_phi, cpu_rise, cpu_fall
  );

  modport slave (
    input  load_valid, load_data, halt, step,
    output load_ready, load_err, halted, cpu_phi, mem_phi, vid_phi, cpu_rise, cpu_fall
  );
endinterface
`default_nettype wire

// File: rtl/clock_phase_gen_tick_counter.sv
`default_nettype none
// ============================================================================
// phase_tick_counter : wrapping 0..modulus-1 counter with terminal count
// Rev 1.0 : initial release
// ============================================================================
module phase_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic [W-1:0] modulus,
  output logic         tc
);
  logic [W-1:0] count;

  assign tc = (count == (modulus - W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || tc) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/clock_phase_gen.sv
`default_nettype none
// ============================================================================
// clock_phase_gen : cpu/mem/vid phase clocks from CLOCK_50 with halt/step
//                   and a runtime reload port. CLKDIV_SIM_FAST_EN selects
//                   the short reset half period for fast simulation.
// Rev 1.0 : initial release
// ============================================================================
module clock_phase_gen
  import clk_phase_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int HALF_DEFAULT = 40,
  parameter int HALF_SIM     = 8,
  parameter int MEM_MULT     = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  clock_phase_gen_if.slave bus
);
  localparam int MEM_SHIFT = mult_shift(MEM_MULT);
`ifdef CLKDIV_SIM_FAST_EN
  localparam bit SIM_FAST = 1'b1;
`else
  localparam bit SIM_FAST = 1'b0;
`endif
  localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(SIM_FAST ? HALF_SIM : HALF_DEFAULT);
  localparam logic [CNT_W-1:0] MEM_INIT  = HALF_INIT >> MEM_SHIFT;

  logic [CNT_W-1:0] half_q, mem_half, pend_val;
  logic             pend, apply, boundary, mem_tc;
  logic             cpu_phi, mem_phi, vid_phi, cpu_rise, cpu_fall;
  logic             halted, load_err, step_pending;
  cpu_state_t       state;

  assign apply = boundary & pend;

  phase_tick_counter #(.W(CNT_W)) u_major (
    .clk(CLOCK_50), .rst(reset), .restart(apply), .modulus(half_q), .tc(boundary)
  );

  // Restarting at every boundary keeps mem phases aligned to the cpu period
  phase_tick_counter #(.W(CNT_W)) u_minor (
    .clk(CLOCK_50), .rst(reset), .restart(boundary), .modulus(mem_half), .tc(mem_tc)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      half_q   <= HALF_INIT;
      mem_half <= MEM_INIT;
      pend     <= 1'b0;
      pend_val <= '0;
      load_err <= 1'b0;
      mem_phi  <= 1'b1;
      vid_phi  <= 1'b1;
    end else begin
      load_err <= 1'b0;
      if (mem_tc)   mem_phi <= ~mem_phi;
      if (boundary) vid_phi <= ~vid_phi;
      if (bus.load_valid && !pend) begin
        if (legal_half(32'(bus.load_data), MEM_MULT)) begin
          pend     <= 1'b1;
          pend_val <= bus.load_data;
        end else begin
          load_err <= 1'b1;
        end
      end
      // A value captured on a boundary edge waits for the next one
      if (apply) begin
        half_q   <= pend_val;
        mem_half <= pend_val >> MEM_SHIFT;
        pend     <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      cpu_phi      <= 1'b0;
      cpu_rise     <= 1'b0;
      cpu_fall     <= 1'b0;
      halted       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      cpu_rise <= 1'b0;
      cpu_fall <= 1'b0;
      if (bus.step && state == HALTED) step_pending <= 1'b1;
      if (boundary) begin
        case (state)
          RUN: begin
            if (!cpu_phi && bus.halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              cpu_phi  <= ~cpu_phi;
              cpu_rise <= ~cpu_phi;
              cpu_fall <= cpu_phi;
            end
          end
          HALTED: begin
            if (!bus.halt || step_pending) begin
              state        <= bus.halt ? STEP : RUN;
              cpu_phi      <= 1'b1;
              cpu_rise     <= 1'b1;
              halted       <= 1'b0;
              step_pending <= 1'b0;
            end
          end
          STEP: begin
            state    <= RUN;
            cpu_phi  <= 1'b0;
            cpu_fall <= 1'b1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign bus.load_ready = ~pend;
  assign bus.load_err   = load_err;
  assign bus.halted     = halted;
  assign bus.cpu_phi    = cpu_phi;
  assign bus.mem_phi    = mem_phi;
  assign bus.vid_phi    = vid_phi;
  assign bus.cpu_rise   = cpu_rise;
  assign bus.cpu_fall   = cpu_fall;
endmodule
`default_nettype wire

// File: tb/tb_clock_phase_gen.sv
`default_nettype none
// ============================================================================
// tb_clock_phase_gen : directed anchors plus randomized traffic against a
//                      period-arithmetic model of the phase generator
// Rev 1.0 : initial release
// ============================================================================
module tb_clock_phase_gen;
  localparam int CNT_W    = 8;
  localparam int MEM_MULT = 4;
  localparam int HALF_RST = 40;
  localparam int RUNNING  = 0;
  localparam int PARKED   = 1;
  localparam int STEPPING = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  clock_phase_gen_if #(.CNT_W(CNT_W)) bus ();

  clock_phase_gen #(
    .CNT_W(CNT_W), .HALF_DEFAULT(HALF_RST), .HALF_SIM(8), .MEM_MULT(MEM_MULT)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  // Model: position inside the current cpu half period plus output levels
  int m_half, m_pos, m_pend_val, m_mode;
  bit m_pend, m_cpu, m_mem, m_vid, m_rise, m_fall, m_err, m_step_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_half = HALF_RST; m_pos = 0; m_pend = 0; m_pend_val = 0;
    m_mode = RUNNING; m_cpu = 0; m_mem = 1; m_vid = 1;
    m_rise = 0; m_fall = 0; m_err = 0; m_step_req = 0;
  endtask

  // Advance the model by one CLOCK_50 edge using the inputs seen at that edge
  task automatic model_edge();
    bit bnd, mtog, req, had_pend;
    int ld;
    bnd      = ((m_pos + 1) % m_half) == 0;
    mtog     = ((m_pos + 1) % (m_half / MEM_MULT)) == 0;
    req      = m_step_req;
    had_pend = m_pend;
    ld       = int'(bus.load_data);
    m_rise = 0; m_fall = 0; m_err = 0;
    if (mtog) m_mem = ~m_mem;
    if (bnd)  m_vid = ~m_vid;
    if (bus.step && m_mode == PARKED) m_step_req = 1;
    if (bnd) begin
      if (m_mode == RUNNING) begin
        if (!m_cpu && bus.halt) m_mode = PARKED;
        else begin
          m_cpu = ~m_cpu;
          if (m_cpu) m_rise = 1; else m_fall = 1;
        end
      end else if (m_mode == PARKED) begin
        if (!bus.halt || req) begin
          m_mode = bus.halt ? STEPPING : RUNNING;
          m_cpu = 1; m_rise = 1; m_step_req = 0;
        end
      end else begin
        m_cpu = 0; m_fall = 1; m_mode = RUNNING;
      end
    end
    if (bus.load_valid && !m_pend) begin
      if ((ld % MEM_MULT) == 0 && ld >= 2 * MEM_MULT) begin
        m_pend = 1; m_pend_val = ld;
      end else m_err = 1;
    end
    if (bnd && had_pend) begin
      m_half = m_pend_val; m_pend = 0;
    end
    m_pos = bnd ? 0 : m_pos + 1;
  endtask

  task automatic compare_all();
    check("cpu_phi",    32'(bus.cpu_phi),    32'(m_cpu));
    check("mem_phi",    32'(bus.mem_phi),    32'(m_mem));
    check("vid_phi",    32'(bus.vid_phi),    32'(m_vid));
    check("cpu_rise",   32'(bus.cpu_rise),   32'(m_rise));
    check("cpu_fall",   32'(bus.cpu_fall),   32'(m_fall));
    check("halted",     32'(bus.halted),     32'(m_mode == PARKED));
    check("load_ready", 32'(bus.load_ready), 32'(!m_pend));
    check("load_err",   32'(bus.load_err),   32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.halt = 1'b0; bus.step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_phi",    32'(bus.cpu_phi),    0);
    check("rst_mem_phi",    32'(bus.mem_phi),    1);
    check("rst_vid_phi",    32'(bus.vid_phi),    1);
    check("rst_halted",     32'(bus.halted),     0);
    check("rst_load_ready", 32'(bus.load_ready), 1);
    check("rst_strobes",    32'({bus.cpu_rise, bus.cpu_fall, bus.load_err}), 0);
    model_reset();
    cyc = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Defaults after reset release
    do_reset();
    run_to(10); check("a_mem10", 32'(bus.mem_phi), 0);
    run_to(39); check("a_rise39", 32'(bus.cpu_rise), 0);
    run_to(40); check("a_cpu40", 32'(bus.cpu_phi), 1); check("a_rise40", 32'(bus.cpu_rise), 1);
    check("a_vid40", 32'(bus.vid_phi), 0);
    run_to(41); check("a_rise41", 32'(bus.cpu_rise), 0);
    run_to(49); check("a_mem49", 32'(bus.mem_phi), 1);
    run_to(50); check("a_mem50", 32'(bus.mem_phi), 0);
    run_to(80); check("a_cpu80", 32'(bus.cpu_phi), 0);
    run_to(120); check("a_cpu120", 32'(bus.cpu_phi), 1);

    // Legal reload
    do_reset();
    run_to(24); bus.load_valid = 1'b1; bus.load_data = 8'd16;
    tick(); bus.load_valid = 1'b0;
    check("b_ready25", 32'(bus.load_ready), 0);
    run_to(39); check("b_ready39", 32'(bus.load_ready), 0);
    run_to(41); check("b_ready41", 32'(bus.load_ready), 1);
    run_to(44); check("b_mem44", 32'(bus.mem_phi), 0);
    run_to(56); check("b_fall56", 32'(bus.cpu_fall), 1);

    // Illegal reloads
    do_reset();
    run_to(9); bus.load_valid = 1'b1; bus.load_data = 8'd6;
    tick(); check("c_err6", 32'(bus.load_err), 1); check("c_rdy6", 32'(bus.load_ready), 1);
    bus.load_data = 8'd0;
    tick(); check("c_err0", 32'(bus.load_err), 1);
    bus.load_valid = 1'b0;
    tick(); check("c_err_clr", 32'(bus.load_err), 0);
    run_to(79); check("c_cpu79", 32'(bus.cpu_phi), 1);
    run_to(80); check("c_cpu80", 32'(bus.cpu_phi), 0);

    // Halt then single step, with a second step ignored during the step
    do_reset();
    run_to(49); bus.halt = 1'b1;
    run_to(80); check("d_fall80", 32'(bus.cpu_fall), 1);
    run_to(119); check("d_halt119", 32'(bus.halted), 0);
    run_to(120); check("d_halt120", 32'(bus.halted), 1); check("d_cpu120", 32'(bus.cpu_phi), 0);
    run_to(169); bus.step = 1'b1; tick(); bus.step = 1'b0;
    run_to(200); check("d_rise200", 32'(bus.cpu_rise), 1); check("d_halt200", 32'(bus.halted), 0);
    run_to(209); bus.step = 1'b1; tick(); bus.step = 1'b0;
    run_to(240); check("d_fall240", 32'(bus.cpu_fall), 1);
    run_to(280); check("d_halt280", 32'(bus.halted), 1);
    run_to(320); check("d_cpu320", 32'(bus.cpu_phi), 0); check("d_rise320", 32'(bus.cpu_rise), 0);

    // Async reset while parked with a load pending
    run_to(324); bus.load_valid = 1'b1; bus.load_data = 8'd24;
    tick(); bus.load_valid = 1'b0;
    run_to(330);
    check("e_pre_halted", 32'(bus.halted), 1); check("e_pre_ready", 32'(bus.load_ready), 0);
    #2 rst = 1'b1;
    #1;
    check("e_cpu",    32'(bus.cpu_phi),    0);
    check("e_mem",    32'(bus.mem_phi),    1);
    check("e_vid",    32'(bus.vid_phi),    1);
    check("e_halted", 32'(bus.halted),     0);
    check("e_ready",  32'(bus.load_ready), 1);
    do_reset();
    run_to(39); check("e_cpu39", 32'(bus.cpu_phi), 0);
    run_to(40); check("e_cpu40", 32'(bus.cpu_phi), 1);

    // Randomized reloads, halts and steps
    for (int i = 0; i < 4000; i++) begin
      bus.load_valid = ($urandom_range(0, 15) == 0);
      bus.load_data  = 8'($urandom_range(0, 60));
      bus.step       = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 149) == 0) bus.halt = ~bus.halt;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
